// File: rtl/lcd_init_sequencer.sv
// Power-on sequencer for the static-screen LCD: plays the init ROM table into the
// byte transmitter after the reset pulser finishes, then hands TX to the pixel stream.
module lcd_init_sequencer #(
  parameter int AW         = 6,
  parameter int DELAY_UNIT = 1000,
  parameter int DW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rst_done,
  output logic [AW-1:0] rom_addr,
  input  logic [9:0]    rom_data,
  output logic          tx_valid,
  output logic [7:0]    tx_byte,
  output logic          tx_dc,
  input  logic          tx_ready,
  input  logic          pix_valid,
  input  logic [7:0]    pix_byte,
  output logic          pix_ready,
  output logic          busy,
  output logic          init_done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RST, S_FETCH, S_DECODE, S_SEND, S_DELAY, S_DONE, S_ERR
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic [DW-1:0] UNIT      = DW'(DELAY_UNIT);

  state_t        state_reg, state_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [7:0]    byte_reg, byte_next;
  logic          dc_reg, dc_next;
  logic [DW-1:0] cnt_reg, cnt_next;
  logic          entry_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      byte_reg  <= '0;
      dc_reg    <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      byte_reg  <= byte_next;
      dc_reg    <= dc_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    byte_next  = byte_reg;
    dc_next    = dc_reg;
    cnt_next   = cnt_reg;
    entry_done = 1'b0;
    case (state_reg)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_next = S_WAIT_RST;
          addr_next  = '0;
        end
      end
      S_WAIT_RST: if (rst_done) state_next = S_FETCH;
      S_FETCH:    state_next = S_DECODE;
      S_DECODE: begin
        case (rom_data[9:8])
          2'b00, 2'b01: begin
            byte_next  = rom_data[7:0];
            dc_next    = rom_data[8];
            state_next = S_SEND;
          end
          2'b10: begin
            if (rom_data[7:0] != 8'd0) begin
              // Counter ends at 0 on the last delay cycle, so N*UNIT cycles total.
              cnt_next   = DW'(rom_data[7:0]) * UNIT - DW'(1);
              state_next = S_DELAY;
            end else begin
              entry_done = 1'b1;
            end
          end
          default: state_next = S_DONE;
        endcase
      end
      S_SEND: if (tx_ready) entry_done = 1'b1;
      S_DELAY: begin
        if (cnt_reg == '0) entry_done = 1'b1;
        else               cnt_next   = cnt_reg - DW'(1);
      end
      S_DONE:  state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
    // Running past the last table slot is an error; the address is not wrapped.
    if (entry_done) begin
      if (addr_reg == LAST_ADDR) begin
        state_next = S_ERR;
      end else begin
        addr_next  = addr_reg + AW'(1);
        state_next = S_FETCH;
      end
    end
  end

  always_comb begin
    rom_addr  = addr_reg;
    tx_valid  = (state_reg == S_SEND);
    tx_byte   = byte_reg;
    tx_dc     = dc_reg;
    pix_ready = 1'b0;
    busy      = (state_reg == S_WAIT_RST) || (state_reg == S_FETCH) ||
                (state_reg == S_DECODE) || (state_reg == S_SEND) ||
                (state_reg == S_DELAY);
    init_done = (state_reg == S_DONE);
    err       = (state_reg == S_ERR);
    if (state_reg == S_DONE) begin
      tx_valid  = pix_valid;
      tx_byte   = pix_byte;
      tx_dc     = 1'b1;
      pix_ready = tx_ready;
    end
  end

endmodule
